// File: rtl/bcd_entry_ctrl.sv
// rtl/bcd_entry_ctrl.sv - three-digit BCD operand entry with debounced key and valid/ready offer
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   key_in      raw digit-enter pushbutton (async, active-high)
//   key_num     BCD digit switches, sampled on an accepted press
//   sign_sw     negative-sign switch (async), sampled on the confirm press
//   opnd_ready  consumer accepts the offered operand
//   opnd_valid  a committed operand is offered
//   opnd_bcd    {huns, tens, ones} of the offered operand
//   opnd_neg    sign of the offered operand
//   opnd_sel    0 = operand A, 1 = operand B
//   track_led   one-hot entry position (1111 while offering)
//   err         sticky invalid-digit flag
module bcd_entry_ctrl #(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_in,
  input  logic [3:0]  key_num,
  input  logic        sign_sw,
  input  logic        opnd_ready,
  output logic        opnd_valid,
  output logic [11:0] opnd_bcd,
  output logic        opnd_neg,
  output logic        opnd_sel,
  output logic [3:0]  track_led,
  output logic        err
);

  typedef enum logic [2:0] {DIG0, DIG1, DIG2, CONFIRM, OFFER} state_t;

  localparam int CW = $clog2(DEB_CYCLES + 3);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);
  // Arming needs DEB_CYCLES real low samples; the two extra cover the
  // synchronizer's reset zeros, which are not genuine samples of the key.
  localparam logic [CW-1:0] ARM_MAX = CW'(DEB_CYCLES + 1);

  logic key_meta, key_s;
  logic sign_meta, sign_s;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] arm_cnt;
  logic deb_level, deb_prev, armed;
  logic press;

  state_t state;
  logic [3:0] ones, tens, huns;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta  <= 1'b0;
      key_s     <= 1'b0;
      sign_meta <= 1'b0;
      sign_s    <= 1'b0;
    end else begin
      key_meta  <= key_in;
      key_s     <= key_meta;
      sign_meta <= sign_sw;
      sign_s    <= sign_meta;
    end
  end

  // Debounce: deb_cnt counts consecutive samples that differ from the
  // accepted level; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      deb_prev <= deb_level;
      if (key_s == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        deb_level <= key_s;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // A key held through reset release must be seen released before any
  // rising edge counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      if (key_s) begin
        arm_cnt <= '0;
      end else if (arm_cnt == ARM_MAX) begin
        armed <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  assign press = deb_level && !deb_prev && armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DIG0;
      ones       <= 4'd0;
      tens       <= 4'd0;
      huns       <= 4'd0;
      opnd_valid <= 1'b0;
      opnd_bcd   <= 12'h000;
      opnd_neg   <= 1'b0;
      opnd_sel   <= 1'b0;
      track_led  <= 4'b0001;
      err        <= 1'b0;
    end else begin
      case (state)
        DIG0, DIG1, DIG2: begin
          if (press) begin
            if (key_num > 4'd9) begin
              err <= 1'b1;
            end else begin
              err <= 1'b0;
              case (state)
                DIG0: begin
                  ones      <= key_num;
                  state     <= DIG1;
                  track_led <= 4'b0010;
                end
                DIG1: begin
                  tens      <= key_num;
                  state     <= DIG2;
                  track_led <= 4'b0100;
                end
                default: begin
                  huns      <= key_num;
                  state     <= CONFIRM;
                  track_led <= 4'b1000;
                end
              endcase
            end
          end
        end
        CONFIRM: begin
          if (press) begin
            opnd_bcd   <= {huns, tens, ones};
            opnd_neg   <= sign_s;
            opnd_valid <= 1'b1;
            state      <= OFFER;
            track_led  <= 4'b1111;
          end
        end
        OFFER: begin
          // Presses are ignored here; only the handshake moves on.
          if (opnd_valid && opnd_ready) begin
            opnd_valid <= 1'b0;
            opnd_sel   <= ~opnd_sel;
            ones       <= 4'd0;
            tens       <= 4'd0;
            huns       <= 4'd0;
            state      <= DIG0;
            track_led  <= 4'b0001;
          end
        end
        default: begin
          state      <= DIG0;
          opnd_valid <= 1'b0;
          track_led  <= 4'b0001;
        end
      endcase
    end
  end

endmodule
